// File: rtl/big_core_kbd_frame_checker_if.sv
// Bit-serial keyboard frame link between the bit sampler and the frame checker.
// master: bit sampler side (drives strobes); slave: frame checker side.
interface big_core_kbd_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              bit_valid;
  logic              bit_in;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              parity_err;
  logic              stop_err;
  logic              start_err;
  logic              timeout_err;
  logic              busy;

  modport master (
    output bit_valid, bit_in,
    input  frame_data, frame_valid, parity_err, stop_err,
           start_err, timeout_err, busy
  );

  modport slave (
    input  bit_valid, bit_in,
    output frame_data, frame_valid, parity_err, stop_err,
           start_err, timeout_err, busy
  );
endinterface

// File: rtl/big_core_kbd_frame_checker.sv
// Keyboard frame receiver/checker: assembles start, LSB-first data, optional
// parity and stop bits from pre-sampled bit strobes, and flags framing errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a 0 start bit; a 1 here is a start error
// S_DATA   | shifting DATA_W data bits, LSB first
// S_PARITY | checking the parity bit (skipped when PARITY_MODE = 0)
// S_STOP   | collecting STOP_BITS stop bits, then publishing the frame
module big_core_kbd_frame_checker #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int TIMEOUT_CYC = 2000
) (
  input logic Clk,
  input logic Rst,
  big_core_kbd_frame_checker_if.slave kbd
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  // Counter value one cycle before it would reach TIMEOUT_CYC.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              xor_q, xor_d;
  logic              perr_acc_q, perr_acc_d;
  logic              stop_acc_q, stop_acc_d;
  logic [DATA_W-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              stop_err_q, stop_err_d;
  logic              start_err_q, start_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic              ones;
  logic              tmo_hit;

  // A strobe arriving on the would-be timeout cycle takes priority.
  assign tmo_hit = (state_q != S_IDLE) && !kbd.bit_valid && (tmo_cnt_q == TMO_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmo_cnt_q     <= '0;
      shreg_q       <= '0;
      xor_q         <= 1'b0;
      perr_acc_q    <= 1'b0;
      stop_acc_q    <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      stop_err_q    <= 1'b0;
      start_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      shreg_q       <= shreg_d;
      xor_q         <= xor_d;
      perr_acc_q    <= perr_acc_d;
      stop_acc_q    <= stop_acc_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      stop_err_q    <= stop_err_d;
      start_err_q   <= start_err_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state selection; a timeout overrides any frame progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (kbd.bit_valid && !kbd.bit_in) state_d = S_DATA;
      end
      S_DATA: begin
        if (kbd.bit_valid && (cnt_q == LAST_DATA))
          state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
      end
      S_PARITY: begin
        if (kbd.bit_valid) state_d = S_STOP;
      end
      S_STOP: begin
        if (kbd.bit_valid && (cnt_q == LAST_STOP)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  // Datapath and registered outputs; pulses default low, levels hold.
  always_comb begin
    cnt_d         = cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    shreg_d       = shreg_q;
    xor_d         = xor_q;
    perr_acc_d    = perr_acc_q;
    stop_acc_d    = stop_acc_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    parity_err_d  = parity_err_q;
    stop_err_d    = stop_err_q;
    start_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    busy_d        = (state_d != S_IDLE);
    ones          = xor_q ^ kbd.bit_in;

    // Inter-bit gap counter; leaves at TIMEOUT_CYC so it never wraps.
    if (state_q != S_IDLE)
      tmo_cnt_d = kbd.bit_valid ? '0 : tmo_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (kbd.bit_valid) begin
          if (kbd.bit_in) begin
            start_err_d = 1'b1;
          end else begin
            cnt_d      = '0;
            xor_d      = 1'b0;
            perr_acc_d = 1'b0;
            stop_acc_d = 1'b0;
            tmo_cnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (kbd.bit_valid) begin
          for (int i = 0; i < DATA_W; i++)
            if (cnt_q == CNT_W'(i)) shreg_d[i] = kbd.bit_in;
          xor_d = xor_q ^ kbd.bit_in;
          cnt_d = (cnt_q == LAST_DATA) ? '0 : cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (kbd.bit_valid)
          perr_acc_d = (PARITY_MODE == 1) ? !ones : ones;
      end
      S_STOP: begin
        if (kbd.bit_valid) begin
          stop_acc_d = stop_acc_q | !kbd.bit_in;
          if (cnt_q == LAST_STOP) begin
            cnt_d         = '0;
            frame_valid_d = 1'b1;
            frame_data_d  = shreg_q;
            parity_err_d  = perr_acc_q;
            stop_err_d    = stop_acc_q | !kbd.bit_in;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (tmo_hit) timeout_err_d = 1'b1;
  end

  assign kbd.frame_data  = frame_data_q;
  assign kbd.frame_valid = frame_valid_q;
  assign kbd.parity_err  = parity_err_q;
  assign kbd.stop_err    = stop_err_q;
  assign kbd.start_err   = start_err_q;
  assign kbd.timeout_err = timeout_err_q;
  assign kbd.busy        = busy_q;

endmodule

// File: tb/tb_big_core_kbd_frame_checker.sv
// Scoreboard bench for the keyboard frame checker. Instance A: 8 data bits,
// odd parity, 1 stop, 16-cycle timeout. Instance B: 7 data bits, even parity,
// 2 stops. Stimulus pushes expected events; negedge monitors pop and compare.
module tb_big_core_kbd_frame_checker;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int kind;   // 0 frame_valid, 1 start_err, 2 timeout_err
    int data;
    int perr;
    int serr;
    int due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  big_core_kbd_frame_checker_if #(.DATA_W(8)) ifa();
  big_core_kbd_frame_checker_if #(.DATA_W(7)) ifb();

  big_core_kbd_frame_checker #(
    .DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .TIMEOUT_CYC(16)
  ) u_a (
    .Clk(Clk), .Rst(Rst), .kbd(ifa.slave)
  );

  big_core_kbd_frame_checker #(
    .DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2), .TIMEOUT_CYC(2000)
  ) u_b (
    .Clk(Clk), .Rst(Rst), .kbd(ifb.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int w, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h (cycle %0d)", name, w, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int w, input int kind, input int data,
                          input int perr, input int serr, input int due);
    exp_t e;
    e.kind = kind; e.data = data; e.perr = perr; e.serr = serr; e.due = due;
    if (w == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic mon(input int w, input logic fv, input logic se, input logic te,
                     input logic bsy, input logic [15:0] fd, input logic pe,
                     input logic sr);
    exp_t e;
    int   kind;
    if (!(fv || se || te)) return;
    kind = fv ? 0 : (se ? 1 : 2);
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event dut=%0d got kind=%0d exp none (cycle %0d)", w, kind, cyc);
      return;
    end
    e = (w == 0) ? qa.pop_front() : qb.pop_front();
    chk("event_kind", w, kind, e.kind);
    chk("event_cycle", w, cyc, e.due);
    chk("single_pulse", w, int'(fv) + int'(se) + int'(te), 1);
    chk("busy_low_at_event", w, int'(bsy), 0);
    if (kind != 1) begin
      chk("frame_data", w, int'(fd), e.data);
      chk("parity_err", w, int'(pe), e.perr);
      chk("stop_err", w, int'(sr), e.serr);
    end
  endtask

  always @(negedge Clk)
    mon(0, ifa.frame_valid, ifa.start_err, ifa.timeout_err, ifa.busy,
        16'(ifa.frame_data), ifa.parity_err, ifa.stop_err);

  always @(negedge Clk)
    mon(1, ifb.frame_valid, ifb.start_err, ifb.timeout_err, ifb.busy,
        16'(ifb.frame_data), ifb.parity_err, ifb.stop_err);

  // Strobe one bit; returns just after the sampling edge.
  task automatic drive_bit(input int w, input logic b);
    if (w == 0) begin ifa.bit_valid = 1'b1; ifa.bit_in = b; end
    else        begin ifb.bit_valid = 1'b1; ifb.bit_in = b; end
    @(posedge Clk);
    #1;
    ifa.bit_valid = 1'b0;
    ifb.bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk_zero(input int w, input string tag);
    if (w == 0) begin
      chk({tag, "_frame_data"}, w, int'(ifa.frame_data), 0);
      chk({tag, "_frame_valid"}, w, int'(ifa.frame_valid), 0);
      chk({tag, "_parity_err"}, w, int'(ifa.parity_err), 0);
      chk({tag, "_stop_err"}, w, int'(ifa.stop_err), 0);
      chk({tag, "_start_err"}, w, int'(ifa.start_err), 0);
      chk({tag, "_timeout_err"}, w, int'(ifa.timeout_err), 0);
      chk({tag, "_busy"}, w, int'(ifa.busy), 0);
    end else begin
      chk({tag, "_frame_data"}, w, int'(ifb.frame_data), 0);
      chk({tag, "_frame_valid"}, w, int'(ifb.frame_valid), 0);
      chk({tag, "_busy"}, w, int'(ifb.busy), 0);
    end
  endtask

  // Full frame: start, nbits data LSB first, optional parity, nstop stop bits
  // (stops[0] first). gap idle cycles follow every bit except the last stop.
  task automatic send_frame(input int w, input int nbits, input logic [15:0] data,
                            input int has_par, input logic pbit, input int nstop,
                            input logic [1:0] stops, input int gap,
                            input int exp_data, input int exp_perr, input int exp_serr);
    drive_bit(w, 1'b0);
    chk("busy_rise", w, int'((w == 0) ? ifa.busy : ifb.busy), 1);
    idle(gap);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(w, data[i]);
      idle(gap);
    end
    if (has_par != 0) begin
      drive_bit(w, pbit);
      idle(gap);
    end
    for (int i = 0; i < nstop; i++) begin
      if (i == nstop - 1) begin
        push_exp(w, 0, exp_data, exp_perr, exp_serr, cyc + 1);
        drive_bit(w, stops[i]);
      end else begin
        drive_bit(w, stops[i]);
        idle(gap);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.bit_valid = 1'b0; ifa.bit_in = 1'b0;
    ifb.bit_valid = 1'b0; ifb.bit_in = 1'b0;
    Rst = 1'b1;
    idle(3);
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    Rst = 1'b0;
    idle(2);

    // Odd parity: 0x1C has three ones, parity bit 0 is correct.
    send_frame(0, 8, 16'h1C, 1, 1'b0, 1, 2'b01, 0, 'h1C, 0, 0);
    // Back-to-back (start strobed during frame_valid): wrong parity bit 1.
    send_frame(0, 8, 16'h1C, 1, 1'b1, 1, 2'b01, 0, 'h1C, 1, 0);
    // 0xF0 has four ones, parity 1 correct: clears parity_err.
    send_frame(0, 8, 16'hF0, 1, 1'b1, 1, 2'b01, 0, 'hF0, 0, 0);
    // 0x5A four ones, parity 1 correct, stop bit 0.
    send_frame(0, 8, 16'h5A, 1, 1'b1, 1, 2'b00, 2, 'h5A, 0, 1);
    idle(2);

    // 1 in IDLE: start_err pulse, busy stays low.
    push_exp(0, 1, 0, 0, 0, cyc + 1);
    drive_bit(0, 1'b1);
    chk("busy_after_start_err", 0, int'(ifa.busy), 0);
    idle(3);

    // Start plus 3 data bits then silence: timeout 16 cycles after last strobe,
    // previous frame_data and error levels retained.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    push_exp(0, 2, 'h5A, 0, 1, cyc + 17);
    drive_bit(0, 1'b1);
    idle(20);
    chk("busy_after_timeout", 0, int'(ifa.busy), 0);

    // 15 idle cycles between strobes: strobe lands on the would-be timeout
    // cycle and wins, frame decodes normally.
    send_frame(0, 8, 16'h1C, 1, 1'b0, 1, 2'b01, 15, 'h1C, 0, 0);
    idle(3);

    // Reset after 5 bits (start + 4 data): everything zero, no frame_valid.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk_zero(0, "midframe_reset");
    idle(3);
    send_frame(0, 8, 16'h1C, 1, 1'b0, 1, 2'b01, 0, 'h1C, 0, 0);
    idle(3);

    // Instance B: 0x41 has two ones, even parity bit 0, stops 1,1.
    send_frame(1, 7, 16'h41, 1, 1'b0, 2, 2'b11, 0, 'h41, 0, 0);
    // Second stop bit 0.
    send_frame(1, 7, 16'h41, 1, 1'b0, 2, 2'b01, 0, 'h41, 0, 1);
    // Wrong even parity.
    send_frame(1, 7, 16'h41, 1, 1'b1, 2, 2'b11, 0, 'h41, 1, 0);
    idle(5);

    chk("queue_a_drained", 0, qa.size(), 0);
    chk("queue_b_drained", 1, qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
